// File: rtl/dice_pkg.sv
// Shared definitions for the two-player dice turn scheduler:
// FSM state encodings, legal face range and the default win threshold.
package dice_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ROLL   = 3'd1,
        ST_STOP   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    localparam logic [2:0] FACE_MIN      = 3'd1;
    localparam logic [2:0] FACE_MAX      = 3'd6;
    localparam int         WIN_SCORE_DEF = 20;

    // A face outside 1..6 comes from a glitched roller and scores nothing.
    function automatic logic face_ok(input logic [2:0] f);
        return (f >= FACE_MIN) && (f <= FACE_MAX);
    endfunction

endpackage

// File: rtl/dice_turn_sched_rr_arb2.sv
// Two-way round-robin arbiter for simultaneous roll requests.
// Ports: rise[1:0] request rises, ptr last served player, gnt[1:0] one-hot grant.
module rr_arb2 (
    input  logic [1:0] rise,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = rise;
        // On a tie, serve the player that did not go last.
        if (&rise) begin
            gnt = ptr ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dice_turn_sched.sv
// Two-player turn scheduler: arbitrates roll requests, times the roller,
// samples the face, accumulates scores and declares a winner.
// Ports: clk, reset (async high), req[1:0], clr, face[2:0] in;
//        roll_run, roll_stop, grant[1:0], score0, score1, winner[1:0], busy out.
module dice_turn_sched
    import dice_pkg::*;
#(
    parameter int ROLL_CYCLES = 54000000,
    parameter int CNT_W       = 28,
    parameter int SCORE_W     = 6,
    parameter int WIN_SCORE   = WIN_SCORE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic               clr,
    input  logic [2:0]         face,
    output logic               roll_run,
    output logic               roll_stop,
    output logic [1:0]         grant,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [1:0]         winner,
    output logic               busy
);

    localparam int              SUM_W    = SCORE_W + 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROLL_CYCLES - 1);
    localparam logic [SUM_W-1:0] SAT_MAX  = {3'b000, {SCORE_W{1'b1}}};
    localparam logic [31:0]      WIN_U    = WIN_SCORE;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_req_q;
    logic [1:0]         r_grant;
    logic [1:0]         r_winner;
    logic               r_rr_ptr;
    logic [SCORE_W-1:0] r_score0;
    logic [SCORE_W-1:0] r_score1;

    logic [1:0]         w_rise;
    logic [1:0]         w_arb_gnt;
    logic [2:0]         w_add;
    logic [SCORE_W-1:0] w_cur;
    logic [SUM_W-1:0]   w_sum;
    logic [SCORE_W-1:0] w_new;
    logic               w_win;

    assign w_rise = req & ~r_req_q;

    rr_arb2 u_arb (
        .rise (w_rise),
        .ptr  (r_rr_ptr),
        .gnt  (w_arb_gnt)
    );

    // Saturating score update for the granted player.
    assign w_add = face_ok(face) ? face : 3'd0;
    assign w_cur = r_grant[1] ? r_score1 : r_score0;
    assign w_sum = {3'b000, w_cur} + {{SCORE_W{1'b0}}, w_add};
    assign w_new = (w_sum > SAT_MAX) ? {SCORE_W{1'b1}}
                                     : w_sum[SCORE_W-1:0];
    assign w_win = (32'(w_new) >= WIN_U);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (clr) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (|w_rise) w_next = ST_ROLL;
                ST_ROLL:   if (r_cnt == CNT_LAST) w_next = ST_STOP;
                ST_STOP:   w_next = ST_SAMPLE;
                ST_SAMPLE: w_next = w_win ? ST_OVER : ST_IDLE;
                ST_OVER:   w_next = ST_OVER;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_q  <= 2'b00;
            r_cnt    <= '0;
            r_grant  <= 2'b00;
            r_winner <= 2'b00;
            r_rr_ptr <= 1'b0;
            r_score0 <= '0;
            r_score1 <= '0;
        end else begin
            r_req_q <= req;
            if (clr) begin
                r_cnt    <= '0;
                r_grant  <= 2'b00;
                r_winner <= 2'b00;
                r_score0 <= '0;
                r_score1 <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (|w_rise) begin
                            r_grant <= w_arb_gnt;
                            r_cnt   <= '0;
                        end
                    end
                    ST_ROLL: r_cnt <= r_cnt + 1'b1;
                    ST_SAMPLE: begin
                        if (r_grant[0]) r_score0 <= w_new;
                        if (r_grant[1]) r_score1 <= w_new;
                        if (w_win) begin
                            r_winner <= r_grant;
                        end else begin
                            r_rr_ptr <= r_grant[1];
                            r_grant  <= 2'b00;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign roll_run  = (r_state == ST_ROLL);
    assign roll_stop = (r_state == ST_STOP);
    assign busy      = (r_state != ST_IDLE);
    assign grant     = r_grant;
    assign winner    = r_winner;
    assign score0    = r_score0;
    assign score1    = r_score1;

endmodule
